// File: rtl/slink_bist_pkg.sv
// slink_bist_pkg: shared encodings for the S-Link BIST packet generator (payload modes, PRBS select, FSM states, short-packet DI threshold)
package slink_bist_pkg;
  localparam logic [3:0] MODE_AA = 4'd0;
  localparam logic [3:0] MODE_CC = 4'd1;
  localparam logic [3:0] MODE_F0 = 4'd2;
  localparam logic [3:0] MODE_COUNT = 4'd3;
  localparam logic [3:0] MODE_PRBS = 4'd4;
  localparam logic [1:0] PRBS7 = 2'd0;
  localparam logic [1:0] PRBS9 = 2'd1;
  localparam logic [1:0] PRBS15 = 2'd2;
  localparam logic [1:0] PRBS31 = 2'd3;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HDR = 3'd1;
  localparam logic [2:0] ST_PAY = 3'd2;
  localparam logic [2:0] ST_END = 3'd3;
  localparam logic [2:0] ST_GAP = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;
  localparam logic [7:0] DI_SHORT = 8'h20;
  function automatic logic [7:0] fill_byte(input logic [3:0] m);
    return m == MODE_AA ? 8'hAA : m == MODE_CC ? 8'hCC : m == MODE_F0 ? 8'hF0 : 8'hD0;
  endfunction
  function automatic logic [31:0] prbs_mask(input logic [1:0] s);
    return s == PRBS7 ? 32'h7F : s == PRBS9 ? 32'h1FF : s == PRBS15 ? 32'h7FFF : 32'h7FFF_FFFF;
  endfunction
endpackage

// File: rtl/slink_bist_prbs_word.sv
// slink_bist_prbs_word: selectable Fibonacci LFSR producing WIDTH bits per step, LSB first (clk/reset/load/seed/sel/step in, word out)
module slink_bist_prbs_word
  import slink_bist_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [31:0]      seed,
  input  logic [1:0]       sel,
  input  logic             step,
  output logic [WIDTH-1:0] word
);
  logic [31:0] lfsr, nxt, s, mask, seed_m;
  logic fb;
  assign mask = prbs_mask(sel);
  assign seed_m = seed & mask;
  always_comb begin
    word = '0;
    s = lfsr;
    fb = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      fb = sel == PRBS7 ? s[6] ^ s[5] : sel == PRBS9 ? s[8] ^ s[4] : sel == PRBS15 ? s[14] ^ s[13] : s[30] ^ s[27];
      word[k] = fb;
      s = {s[30:0], fb} & mask;
    end
    nxt = s;
  end
  always_ff @(posedge clk) begin
    if (reset) lfsr <= '0;
    else if (load) lfsr <= |seed_m ? seed_m : mask;
    else if (step) lfsr <= nxt;
  end
endmodule

// File: rtl/slink_bist_pkt_gen.sv
// slink_bist_pkt_gen: BIST packet generator for the S-Link TX app interface (swi_* config and advance in; valid/sop/data_id/word_count/app_data and bist status out)
module slink_bist_pkt_gen
  import slink_bist_pkg::*;
#(
  parameter int APP_DATA_WIDTH = 32,
  parameter int APP_DATA_BYTES = APP_DATA_WIDTH / 8,
  parameter int PKT_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      swi_bist_en,
  input  logic                      swi_bist_reset,
  input  logic [3:0]                swi_bist_mode_payload,
  input  logic [1:0]                swi_bist_prbs_sel,
  input  logic [31:0]               swi_bist_seed,
  input  logic                      swi_bist_mode_wc,
  input  logic [15:0]               swi_bist_wc_min,
  input  logic [15:0]               swi_bist_wc_max,
  input  logic                      swi_bist_mode_di,
  input  logic [7:0]                swi_bist_di_min,
  input  logic [7:0]                swi_bist_di_max,
  input  logic [PKT_CNT_WIDTH-1:0]  swi_bist_pkt_limit,
  input  logic [7:0]                swi_bist_gap,
  output logic                      valid,
  output logic                      sop,
  output logic [7:0]                data_id,
  output logic [15:0]               word_count,
  output logic [APP_DATA_WIDTH-1:0] app_data,
  input  logic                      advance,
  output logic                      bist_active,
  output logic                      bist_done,
  output logic [PKT_CNT_WIDTH-1:0]  bist_pkt_count
);
  logic clr, acc, short_pkt, last, lim_hit, start, eop, load_beat;
  logic [2:0] state, state_n;
  logic [3:0] mode_q;
  logic [1:0] sel_q;
  logic [15:0] byte_off, pat_off, wc_n;
  logic [7:0] gap_cnt, di_n;
  logic [APP_DATA_WIDTH-1:0] prbs_word, pat;
  logic [PKT_CNT_WIDTH-1:0] pkt_inc;
  assign clr = reset | swi_bist_reset;
  assign acc = valid & advance;
  assign short_pkt = data_id < DI_SHORT || word_count == '0;
  assign last = {1'b0, byte_off} + 17'(APP_DATA_BYTES) >= {1'b0, word_count};
  assign pkt_inc = &bist_pkt_count ? bist_pkt_count : bist_pkt_count + 1'b1;
  assign lim_hit = |swi_bist_pkt_limit && pkt_inc >= swi_bist_pkt_limit;
  assign start = state == ST_IDLE && swi_bist_en;
  assign eop = state == ST_END;
  assign load_beat = acc && state_n == ST_PAY;
  assign pat_off = state == ST_PAY ? byte_off + 16'(APP_DATA_BYTES) : '0;
  // A field outside [min,max) or with min>max falls back to min, which also gives the wrap.
  assign di_n = swi_bist_mode_di && data_id >= swi_bist_di_min && data_id < swi_bist_di_max ? data_id + 8'd1 : swi_bist_di_min;
  assign wc_n = swi_bist_mode_wc && word_count >= swi_bist_wc_min && word_count < swi_bist_wc_max ? word_count + 16'd1 : swi_bist_wc_min;
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: state_n = swi_bist_en ? ST_HDR : ST_IDLE;
      ST_HDR:  state_n = !acc ? ST_HDR : short_pkt ? ST_END : ST_PAY;
      ST_PAY:  state_n = acc && last ? ST_END : ST_PAY;
      ST_END:  state_n = lim_hit ? ST_DONE : !swi_bist_en ? ST_IDLE : |swi_bist_gap ? ST_GAP : ST_HDR;
      ST_GAP:  state_n = gap_cnt > 8'd1 ? ST_GAP : swi_bist_en ? ST_HDR : ST_IDLE;
      ST_DONE: state_n = swi_bist_en ? ST_DONE : ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end
  always_comb begin
    pat = prbs_word;
    if (mode_q != MODE_PRBS)
      for (int i = 0; i < APP_DATA_BYTES; i++)
        pat[8*i +: 8] = mode_q == MODE_COUNT ? 8'(pat_off + 16'(i)) : fill_byte(mode_q);
  end
  // The seed load must see the live select; steps use the select latched with the packet.
  slink_bist_prbs_word #(.WIDTH(APP_DATA_WIDTH)) u_prbs (
    .clk(clk),
    .reset(clr),
    .load(start),
    .seed(swi_bist_seed),
    .sel(start ? swi_bist_prbs_sel : sel_q),
    .step(load_beat && mode_q == MODE_PRBS),
    .word(prbs_word)
  );
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= ST_IDLE;
      valid <= 1'b0;
      sop <= 1'b0;
      data_id <= '0;
      word_count <= '0;
      app_data <= '0;
      bist_active <= 1'b0;
      bist_done <= 1'b0;
      bist_pkt_count <= '0;
      byte_off <= '0;
      gap_cnt <= '0;
      mode_q <= '0;
      sel_q <= '0;
    end else begin
      state <= state_n;
      valid <= state_n == ST_HDR || state_n == ST_PAY;
      sop <= state_n == ST_HDR;
      bist_active <= !(state_n == ST_IDLE || state_n == ST_DONE);
      bist_done <= state_n == ST_DONE;
      app_data <= load_beat ? pat : state_n == ST_PAY ? app_data : '0;
      byte_off <= state_n != ST_PAY ? '0 : state == ST_PAY && acc ? pat_off : byte_off;
      gap_cnt <= eop ? swi_bist_gap : state == ST_GAP ? gap_cnt - 8'd1 : gap_cnt;
      mode_q <= start || eop ? swi_bist_mode_payload : mode_q;
      sel_q <= start || eop ? swi_bist_prbs_sel : sel_q;
      data_id <= start ? swi_bist_di_min : eop ? di_n : data_id;
      word_count <= start ? swi_bist_wc_min : eop ? wc_n : word_count;
      bist_pkt_count <= start ? '0 : eop ? pkt_inc : bist_pkt_count;
    end
  end
endmodule

// File: tb/tb_slink_bist_pkt_gen.sv
// tb_slink_bist_pkt_gen: directed self-checking bench for slink_bist_pkt_gen at 32- and 64-bit payload widths
module tb_slink_bist_pkt_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1, swi_bist_en = 1'b0, swi_bist_reset = 1'b0, advance = 1'b1;
  logic [3:0] mode = '0;
  logic [1:0] psel = '0;
  logic [31:0] seed = 32'h1FF;
  logic mode_wc = 1'b0, mode_di = 1'b0;
  logic [15:0] wc_min = '0, wc_max = '0, limit = '0;
  logic [7:0] di_min = '0, di_max = '0, gap = '0;
  logic valid_a, sop_a, active_a, done_a, valid_b, sop_b, active_b, done_b;
  logic [7:0] di_a, di_b;
  logic [15:0] wc_a, wc_b, cnt_a, cnt_b;
  logic [31:0] app_a;
  logic [63:0] app_b;
  int errors = 0, checks = 0;
  bit pb[137];
  logic [63:0] exp0, exp1;
  int g, beats;
  int exp_di[6] = '{'h1E, 'h1F, 'h20, 'h21, 'h1E, 'h1F};
  int exp_wc[6] = '{4, 5, 6, 4, 5, 6};
  int exp_bt[6] = '{1, 1, 3, 2, 1, 1};

  slink_bist_pkt_gen #(.APP_DATA_WIDTH(32)) dut_a (
    .clk(clk), .reset(reset), .swi_bist_en(swi_bist_en), .swi_bist_reset(swi_bist_reset),
    .swi_bist_mode_payload(mode), .swi_bist_prbs_sel(psel), .swi_bist_seed(seed),
    .swi_bist_mode_wc(mode_wc), .swi_bist_wc_min(wc_min), .swi_bist_wc_max(wc_max),
    .swi_bist_mode_di(mode_di), .swi_bist_di_min(di_min), .swi_bist_di_max(di_max),
    .swi_bist_pkt_limit(limit), .swi_bist_gap(gap), .valid(valid_a), .sop(sop_a),
    .data_id(di_a), .word_count(wc_a), .app_data(app_a), .advance(advance),
    .bist_active(active_a), .bist_done(done_a), .bist_pkt_count(cnt_a));
  slink_bist_pkt_gen #(.APP_DATA_WIDTH(64)) dut_b (
    .clk(clk), .reset(reset), .swi_bist_en(swi_bist_en), .swi_bist_reset(swi_bist_reset),
    .swi_bist_mode_payload(mode), .swi_bist_prbs_sel(psel), .swi_bist_seed(seed),
    .swi_bist_mode_wc(mode_wc), .swi_bist_wc_min(wc_min), .swi_bist_wc_max(wc_max),
    .swi_bist_mode_di(mode_di), .swi_bist_di_min(di_min), .swi_bist_di_max(di_max),
    .swi_bist_pkt_limit(limit), .swi_bist_gap(gap), .valid(valid_b), .sop(sop_b),
    .data_id(di_b), .word_count(wc_b), .app_data(app_b), .advance(advance),
    .bist_active(active_b), .bist_done(done_b), .bist_pkt_count(cnt_b));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr;
    swi_bist_en = 1'b0;
    swi_bist_reset = 1'b1;
    tick;
    swi_bist_reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 9; i++) pb[i] = 1'b1;
    for (int m = 9; m < 137; m++) pb[m] = pb[m-9] ^ pb[m-5];
    for (int k = 0; k < 64; k++) begin
      exp0[k] = pb[9+k];
      exp1[k] = pb[73+k];
    end
    tick;
    tick;
    chk("rst_valid", valid_a, 0);
    chk("rst_sop", sop_a, 0);
    chk("rst_di", di_a, 0);
    chk("rst_wc", wc_a, 0);
    chk("rst_app", app_a, 0);
    chk("rst_active", active_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_app_b", app_b, 0);
    reset = 1'b0;
    mode = 4'd0; wc_min = 16'd6; wc_max = 16'd6; di_min = 8'h2A; di_max = 8'h2A; limit = 16'd2; gap = 8'd0;
    swi_bist_en = 1'b1;
    for (int p = 0; p < 2; p++) begin
      tick;
      chk("t1_hdr_sop", {valid_a, sop_a}, 2'b11);
      chk("t1_hdr_di", di_a, 8'h2A);
      chk("t1_hdr_wc", wc_a, 16'd6);
      chk("t1_hdr_app", app_a, 0);
      tick;
      chk("t1_pay0", {valid_a, sop_a, app_a}, {2'b10, 32'hAAAAAAAA});
      tick;
      chk("t1_pay1", {valid_a, sop_a, app_a}, {2'b10, 32'hAAAAAAAA});
      tick;
      chk("t1_end_valid", {valid_a, active_a}, 2'b01);
      chk("t1_end_cnt", cnt_a, p);
    end
    tick;
    chk("t1_done", {done_a, active_a, valid_a}, 3'b100);
    chk("t1_cnt2", cnt_a, 2);
    tick;
    chk("t1_done_held", done_a, 1);
    swi_bist_en = 1'b0;
    tick;
    chk("t1_done_clear", done_a, 0);
    chk("t1_cnt_kept", cnt_a, 2);
    clr;
    mode = 4'd3; wc_min = 16'd10; wc_max = 16'd10; limit = 16'd1; advance = 1'b0;
    swi_bist_en = 1'b1;
    tick;
    chk("t2_hdr", sop_a, 1);
    tick;
    chk("t2_hdr_hold", {valid_a, sop_a}, 2'b11);
    advance = 1'b1; tick;
    chk("t2_b0", app_a, 32'h03020100);
    advance = 1'b0; tick;
    chk("t2_b0_hold", {valid_a, app_a}, {1'b1, 32'h03020100});
    advance = 1'b1; tick;
    chk("t2_b1", app_a, 32'h07060504);
    advance = 1'b0; tick;
    chk("t2_b1_hold", {valid_a, app_a}, {1'b1, 32'h07060504});
    advance = 1'b1; tick;
    chk("t2_b2", app_a, 32'h0B0A0908);
    advance = 1'b0; tick;
    chk("t2_b2_hold", {valid_a, app_a}, {1'b1, 32'h0B0A0908});
    advance = 1'b1; tick;
    chk("t2_end", valid_a, 0);
    tick;
    chk("t2_done", {done_a, cnt_a}, {1'b1, 16'd1});
    clr;
    mode = 4'd4; psel = 2'd1; seed = 32'h1FF; wc_min = 16'd8; wc_max = 16'd8; limit = 16'd2;
    swi_bist_en = 1'b1;
    tick;
    tick;
    chk("t3_prbs_b0", app_b, exp0);
    tick;
    chk("t3_end", valid_b, 0);
    tick;
    chk("t3_hdr2", sop_b, 1);
    tick;
    chk("t3_prbs_b1", app_b, exp1);
    clr;
    seed = 32'h0;
    swi_bist_en = 1'b1;
    tick;
    tick;
    chk("t3_seed0", app_b, exp0);
    clr;
    mode = 4'd0; mode_wc = 1'b1; wc_min = 16'd4; wc_max = 16'd6;
    mode_di = 1'b1; di_min = 8'h1E; di_max = 8'h21; limit = 16'd6;
    swi_bist_en = 1'b1;
    tick;
    for (int p = 0; p < 6; p++) begin
      g = 0;
      while (!sop_a && g < 10) begin
        tick;
        g++;
      end
      chk("t4_sop", sop_a, 1);
      chk("t4_di", di_a, exp_di[p]);
      chk("t4_wc", wc_a, exp_wc[p]);
      beats = 0;
      while (valid_a && beats < 10) begin
        beats++;
        tick;
      end
      chk("t4_beats", beats, exp_bt[p]);
    end
    tick;
    chk("t4_done", {done_a, cnt_a}, {1'b1, 16'd6});
    clr;
    mode_wc = 1'b0; mode_di = 1'b0; wc_min = 16'd8; wc_max = 16'd8; di_min = 8'h2A; di_max = 8'h2A;
    limit = 16'd0; gap = 8'd3;
    swi_bist_en = 1'b1;
    tick;
    chk("t5_hdr", sop_a, 1);
    tick;
    tick;
    tick;
    chk("t5_end", {valid_a, active_a}, 2'b01);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("t5_gap", {valid_a, active_a}, 2'b01);
    end
    tick;
    chk("t5_hdr2", sop_a, 1);
    tick;
    swi_bist_en = 1'b0;
    tick;
    chk("t5_completes", {valid_a, app_a}, {1'b1, 32'hAAAAAAAA});
    tick;
    chk("t5_end2", {valid_a, active_a}, 2'b01);
    tick;
    chk("t5_idle", {valid_a, active_a}, 2'b00);
    tick;
    chk("t5_stay_idle", {valid_a, sop_a, active_a}, 3'b000);
    clr;
    mode = 4'd3; mode_wc = 1'b1; wc_min = 16'd8; wc_max = 16'd12; di_min = 8'h30; di_max = 8'h30; gap = 8'd0;
    swi_bist_en = 1'b1;
    tick;
    chk("t6_hdr_wc", {sop_a, wc_a}, {1'b1, 16'd8});
    tick;
    chk("t6_b0", app_a, 32'h03020100);
    tick;
    chk("t6_b1", app_a, 32'h07060504);
    tick;
    tick;
    chk("t6_hdr2_wc", {sop_a, wc_a}, {1'b1, 16'd9});
    chk("t6_cnt1", cnt_a, 1);
    tick;
    chk("t6_p2_b0", app_a, 32'h03020100);
    swi_bist_reset = 1'b1;
    tick;
    chk("t6_rst_flags", {valid_a, sop_a, active_a, done_a}, 4'b0000);
    chk("t6_rst_di", di_a, 0);
    chk("t6_rst_wc", wc_a, 0);
    chk("t6_rst_app", app_a, 0);
    chk("t6_rst_cnt", cnt_a, 0);
    chk("t6_rst_app_b", app_b, 0);
    swi_bist_reset = 1'b0;
    tick;
    chk("t6_restart", {sop_a, di_a, wc_a}, {1'b1, 8'h30, 16'd8});
    chk("t6_restart_cnt", cnt_a, 0);
    tick;
    chk("t6_restart_b0", app_a, 32'h03020100);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
